fdma_wr_arb: RTL and testbench

FDMA_WR_ARB -- requirements
Module: fdma_wr_arb

---
 rtl/fdma_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 18 +
 rtl/fdma_wr_arb.sv | 144 ++++++++++++++
 tb/tb_fdma_wr_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdma_arb_pkg.sv
// Shared types and constants for the two-requester FDMA write arbiter.
package fdma_arb_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned SIZE_W      = 16;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StBusy = 2'd2,
    StDone = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fdma_wr_arb.sv
// Arbitrates two burst writers onto one FDMA write port; beat flow is owned by the downstream.
module fdma_wr_arb
  import fdma_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              ui_clk,
  input  logic              fdma_rstn,

  input  logic              m0_wareq,
  input  logic [31:0]       m0_waddr,
  input  logic [15:0]       m0_wsize,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_wbusy,
  output logic              m0_wvalid,

  input  logic              m1_wareq,
  input  logic [31:0]       m1_waddr,
  input  logic [15:0]       m1_wsize,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_wbusy,
  output logic              m1_wvalid,

  output logic              fdma_wareq,
  output logic [31:0]       fdma_waddr,
  output logic [15:0]       fdma_wsize,
  output logic [DATA_W-1:0] fdma_wdata,
  input  logic              fdma_wbusy,
  input  logic              fdma_wvalid,

  output logic [1:0]        grant,
  output logic              arb_err
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [SIZE_W-1:0] wsize_q, wsize_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [1:0]        pick;
  logic [SIZE_W-1:0] pick_size;
  logic [ADDR_W-1:0] pick_addr;

  // Requests are only consumed in idle; elsewhere they simply wait.
  rr_arb2 u_rr_arb2 (
    .req  ({m1_wareq, m0_wareq}),
    .last (last_q),
    .gnt  (pick)
  );

  assign pick_size = pick[1] ? m1_wsize : m0_wsize;
  assign pick_addr = pick[1] ? m1_waddr : m0_waddr;

  always_ff @(posedge ui_clk) begin
    if (!fdma_rstn) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      waddr_q <= '0;
      wsize_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      waddr_q <= waddr_d;
      wsize_q <= wsize_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    waddr_d = waddr_q;
    wsize_d = wsize_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (|pick) begin
          grant_d = pick;
          waddr_d = pick_addr;
          wsize_d = pick_size;
          if (pick_size == '0) begin
            // Zero-length burst never reaches the FDMA port.
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (fdma_wbusy) begin
          state_d = StBusy;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (cnt_q >= CntLast) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        if (!fdma_wbusy) state_d = StDone;
      end
      StDone: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    fdma_wareq = (state_q == StReq);
    fdma_waddr = waddr_q;
    fdma_wsize = wsize_q;
    fdma_wdata = grant_q[1] ? m1_wdata : m0_wdata;
    m0_wbusy   = grant_q[0];
    m1_wbusy   = grant_q[1];
    m0_wvalid  = fdma_wvalid & (state_q == StBusy) & grant_q[0];
    m1_wvalid  = fdma_wvalid & (state_q == StBusy) & grant_q[1];
    grant      = grant_q;
    arb_err    = err_q;
  end

endmodule

// File: tb/tb_fdma_wr_arb.sv
// Directed bench for fdma_wr_arb: table of single bursts plus hand-written corner sequences.
module tb_fdma_wr_arb;

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned TIMEOUT = 16;

  logic              ui_clk = 1'b0;
  logic              fdma_rstn;
  logic              m0_wareq, m1_wareq;
  logic [31:0]       m0_waddr, m1_waddr;
  logic [15:0]       m0_wsize, m1_wsize;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_wbusy, m1_wbusy, m0_wvalid, m1_wvalid;
  logic              fdma_wareq;
  logic [31:0]       fdma_waddr;
  logic [15:0]       fdma_wsize;
  logic [DATA_W-1:0] fdma_wdata;
  logic              fdma_wbusy, fdma_wvalid;
  logic [1:0]        grant;
  logic              arb_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ui_clk = ~ui_clk;

  fdma_wr_arb #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ui_clk      (ui_clk),
    .fdma_rstn   (fdma_rstn),
    .m0_wareq    (m0_wareq),
    .m0_waddr    (m0_waddr),
    .m0_wsize    (m0_wsize),
    .m0_wdata    (m0_wdata),
    .m0_wbusy    (m0_wbusy),
    .m0_wvalid   (m0_wvalid),
    .m1_wareq    (m1_wareq),
    .m1_waddr    (m1_waddr),
    .m1_wsize    (m1_wsize),
    .m1_wdata    (m1_wdata),
    .m1_wbusy    (m1_wbusy),
    .m1_wvalid   (m1_wvalid),
    .fdma_wareq  (fdma_wareq),
    .fdma_waddr  (fdma_waddr),
    .fdma_wsize  (fdma_wsize),
    .fdma_wdata  (fdma_wdata),
    .fdma_wbusy  (fdma_wbusy),
    .fdma_wvalid (fdma_wvalid),
    .grant       (grant),
    .arb_err     (arb_err)
  );

  typedef struct {
    logic        req0;
    logic        req1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [15:0] s0;
    logic [15:0] s1;
    int          delay;
    int          beats;
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    logic [15:0] exp_s;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    fdma_rstn   = 1'b0;
    m0_wareq    = 1'b0;
    m1_wareq    = 1'b0;
    m0_waddr    = '0;
    m1_waddr    = '0;
    m0_wsize    = '0;
    m1_wsize    = '0;
    m0_wdata    = '0;
    m1_wdata    = '0;
    fdma_wbusy  = 1'b0;
    fdma_wvalid = 1'b0;
    repeat (3) @(negedge ui_clk);
    fdma_rstn = 1'b1;
  endtask

  // Starts and ends on a falling edge; leaves the FSM in BUSY.
  task automatic grant_phase(input logic [1:0] exp_g, input logic [31:0] exp_a,
                             input logic [15:0] exp_s, input int delay, input bit drop);
    int c = 0;
    while (grant == 2'b00 && c < 32) begin
      @(negedge ui_clk);
      c++;
    end
    chk("grant", grant, exp_g);
    chk("fdma_waddr", fdma_waddr, exp_a);
    chk("fdma_wsize", fdma_wsize, exp_s);
    chk("wbusy_owner", {m1_wbusy, m0_wbusy}, exp_g);
    chk("fdma_wareq_up", fdma_wareq, 1'b1);
    if (drop) begin
      if (exp_g[0]) m0_wareq = 1'b0;
      if (exp_g[1]) m1_wareq = 1'b0;
    end
    repeat (delay) @(negedge ui_clk);
    fdma_wbusy = 1'b1;
    @(negedge ui_clk);
    chk("fdma_wareq_drop", fdma_wareq, 1'b0);
  endtask

  task automatic beat_phase(input logic [1:0] g, input int beats);
    int ok_n = 0;
    int other_n = 0;
    int data_n = 0;
    logic [127:0] exp_d;
    for (int i = 0; i < beats; i++) begin
      fdma_wvalid = 1'b1;
      m0_wdata    = 128'(i);
      m1_wdata    = 128'(32'hA5A5_0000 + i);
      #1;
      exp_d = g[1] ? 128'(32'hA5A5_0000 + i) : 128'(i);
      if ((g[0] && m0_wvalid) || (g[1] && m1_wvalid)) ok_n++;
      if ((g[0] && m1_wvalid) || (g[1] && m0_wvalid)) other_n++;
      if (fdma_wdata !== exp_d) data_n++;
      @(negedge ui_clk);
    end
    fdma_wvalid = 1'b0;
    fdma_wbusy  = 1'b0;
    chk("beats_to_owner", ok_n, beats);
    chk("beats_to_other", other_n, 0);
    chk("wdata_route_errs", data_n, 0);
  endtask

  task automatic finish_phase(input logic [1:0] g, input logic exp_err);
    @(negedge ui_clk);
    chk("grant_in_done", grant, g);
    chk("wbusy_in_done", {m1_wbusy, m0_wbusy}, g);
    @(negedge ui_clk);
    chk("grant_idle", grant, 2'b00);
    chk("wbusy_idle", {m1_wbusy, m0_wbusy}, 2'b00);
    chk("arb_err", arb_err, exp_err);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [1:0] exp_g;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_0000, 16'd512, 16'd7,
                3, 512, 2'b01, 32'h0000_1000, 16'd512};
    vecs[1] = '{1'b0, 1'b1, 32'h1111_0000, 32'h2000_0040, 16'd3, 16'd8,
                0, 8, 2'b10, 32'h2000_0040, 16'd8};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_3000, 32'h0000_4000, 16'd4, 16'd6,
                1, 4, 2'b01, 32'h0000_3000, 16'd4};
    // wbusy arrives on the last cycle before timeout; 3 beats against a larger size.
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFF0, 16'd0, 16'hFFFF,
                15, 3, 2'b10, 32'hFFFF_FFF0, 16'hFFFF};

    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_wareq", fdma_wareq, 1'b0);
    chk("rst_waddr", fdma_waddr, 32'h0);
    chk("rst_wsize", fdma_wsize, 16'h0);
    chk("rst_wbusy", {m1_wbusy, m0_wbusy}, 2'b00);
    chk("rst_err", arb_err, 1'b0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      m0_wareq = vecs[v].req0;
      m1_wareq = vecs[v].req1;
      m0_waddr = vecs[v].a0;
      m1_waddr = vecs[v].a1;
      m0_wsize = vecs[v].s0;
      m1_wsize = vecs[v].s1;
      grant_phase(vecs[v].exp_g, vecs[v].exp_a, vecs[v].exp_s, vecs[v].delay, 1'b1);
      beat_phase(vecs[v].exp_g, vecs[v].beats);
      finish_phase(vecs[v].exp_g, 1'b0);
      m0_wareq = 1'b0;
      m1_wareq = 1'b0;
    end

    // Both held continuously: strict alternation starting with requester 0.
    do_reset();
    m0_waddr = 32'h0000_A000; m0_wsize = 16'd2; m0_wareq = 1'b1;
    m1_waddr = 32'h0000_B000; m1_wsize = 16'd2; m1_wareq = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_g = (b % 2 == 0) ? 2'b01 : 2'b10;
      grant_phase(exp_g, exp_g[0] ? 32'h0000_A000 : 32'h0000_B000, 16'd2, 1, 1'b0);
      beat_phase(exp_g, 2);
      finish_phase(exp_g, 1'b0);
    end
    m0_wareq = 1'b0;
    m1_wareq = 1'b0;

    // Downstream never answers: request held exactly TIMEOUT cycles.
    do_reset();
    m0_waddr = 32'h0000_5000; m0_wsize = 16'd4; m0_wareq = 1'b1;
    c = 0;
    while (grant == 2'b00 && c < 32) begin
      @(negedge ui_clk);
      c++;
    end
    m0_wareq = 1'b0;
    c = 0;
    while (fdma_wareq && c < 40) begin
      @(negedge ui_clk);
      c++;
    end
    chk("timeout_cycles", c, TIMEOUT);
    chk("timeout_err", arb_err, 1'b1);
    chk("timeout_done_grant", grant, 2'b01);
    @(negedge ui_clk);
    chk("timeout_idle_grant", grant, 2'b00);
    m1_waddr = 32'h0000_6000; m1_wsize = 16'd2; m1_wareq = 1'b1;
    grant_phase(2'b10, 32'h0000_6000, 16'd2, 2, 1'b1);
    beat_phase(2'b10, 2);
    finish_phase(2'b10, 1'b1);

    // Zero-size grant, then a full m0 burst, then reset in the middle of another.
    do_reset();
    m1_waddr = 32'h0000_7000; m1_wsize = 16'd0; m1_wareq = 1'b1;
    @(negedge ui_clk);
    chk("zero_grant", grant, 2'b10);
    chk("zero_wbusy", {m1_wbusy, m0_wbusy}, 2'b10);
    chk("zero_no_wareq", fdma_wareq, 1'b0);
    chk("zero_err", arb_err, 1'b1);
    m1_wareq = 1'b0;
    @(negedge ui_clk);
    chk("zero_idle_grant", grant, 2'b00);
    chk("zero_idle_wbusy", {m1_wbusy, m0_wbusy}, 2'b00);
    chk("zero_idle_wareq", fdma_wareq, 1'b0);

    m0_waddr = 32'h0000_8000; m0_wsize = 16'd3; m0_wareq = 1'b1;
    grant_phase(2'b01, 32'h0000_8000, 16'd3, 2, 1'b1);
    beat_phase(2'b01, 3);
    finish_phase(2'b01, 1'b1);

    m0_waddr = 32'h0000_9000; m0_wsize = 16'd512; m0_wareq = 1'b1;
    grant_phase(2'b01, 32'h0000_9000, 16'd512, 3, 1'b1);
    for (int i = 0; i < 100; i++) begin
      fdma_wvalid = 1'b1;
      m0_wdata    = 128'(i);
      @(negedge ui_clk);
    end
    fdma_rstn = 1'b0;
    @(negedge ui_clk);
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_wareq", fdma_wareq, 1'b0);
    chk("mid_rst_waddr", fdma_waddr, 32'h0);
    chk("mid_rst_wsize", fdma_wsize, 16'h0);
    chk("mid_rst_wbusy", {m1_wbusy, m0_wbusy}, 2'b00);
    chk("mid_rst_wvalid", {m1_wvalid, m0_wvalid}, 2'b00);
    chk("mid_rst_err", arb_err, 1'b0);
    fdma_wvalid = 1'b0;
    fdma_wbusy  = 1'b0;
    fdma_rstn   = 1'b1;
    m0_waddr = 32'h0000_C000; m0_wsize = 16'd2; m0_wareq = 1'b1;
    m1_waddr = 32'h0000_D000; m1_wsize = 16'd2; m1_wareq = 1'b1;
    grant_phase(2'b01, 32'h0000_C000, 16'd2, 1, 1'b1);
    beat_phase(2'b01, 2);
    finish_phase(2'b01, 1'b0);
    grant_phase(2'b10, 32'h0000_D000, 16'd2, 1, 1'b1);
    beat_phase(2'b10, 2);
    finish_phase(2'b10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
